// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 memory arbiter: read-owner encoding and default sizes.
package mips32_pkg;

    localparam int DEFAULT_AW           = 10;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

endpackage

// File: rtl/mips32_starve_ctr.sv
// Saturating count of consecutive instruction-port denials; flags when the limit is reached.
module mips32_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk1,
    input  logic rst,
    input  logic inc,
    output logic at_limit
);

    localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle without a denial (granted or not requesting) restarts the count.
    always_comb begin
        cnt_d = '0;
        if (inc)
            cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single-ported memory with
// 1-cycle read latency; data has priority unless the fetch port has starved.
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int AW           = DEFAULT_AW,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          halted,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          if_stall,
    output logic          mem_stall
);

    owner_e owner_q, owner_d;
    logic   i_eff, starved;
    logic   gi, gd;

    assign i_eff = i_req & ~halted;

    mips32_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk1     (clk1),
        .rst      (rst),
        .inc      (i_eff & ~gi),
        .at_limit (starved)
    );

    // Outputs are forced low while rst is held so reset is visible immediately.
    always_comb begin
        gi = 1'b0;
        gd = 1'b0;
        if (!rst) begin
            if (i_eff && (starved || !d_req)) gi = 1'b1;
            else if (d_req)                   gd = 1'b1;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        if (gi) begin
            mem_en   = 1'b1;
            mem_addr = i_addr;
            owner_d  = OWN_INSTR;
        end else if (gd) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            owner_d   = d_we ? OWN_NONE : OWN_DATA;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) owner_q <= OWN_NONE;
        else     owner_q <= owner_d;
    end

    assign i_gnt     = gi;
    assign d_gnt     = gd;
    assign if_stall  = ~rst & i_eff & ~gi;
    assign mem_stall = ~rst & d_req & ~gd;

    assign i_rvalid  = (owner_q == OWN_INSTR);
    assign d_rvalid  = (owner_q == OWN_DATA);
    assign i_rdata   = i_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = d_rvalid ? mem_rdata : 32'h0;

endmodule
